// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths, writeback requester ids and request type
package regfile_pkg;
  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 8;
  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_hold_slot.sv
// wb_hold_slot: one-entry writeback holding slot (valid/addr/data/age); load captures, free releases, load wins on refill
module wb_hold_slot import regfile_pkg::*; #(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load,
  input  logic              free,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_age,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              age
);
  // age=1 means older than the other slot; an entry that survives an edge is always the older one
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid <= 1'b0;
      addr <= '0;
      data <= '0;
      age <= 1'b0;
    end else begin
      valid <= load | (valid & !free);
      age <= load ? load_age : 1'b1;
      if (load) begin
        addr <= load_addr;
        data <= load_data;
      end
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: arbitrates ALU (req0) and load (req1) writebacks onto the single RF write port, flags read hazards
module regfile_write_arbiter import regfile_pkg::*; #(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0_VALID,
  input  logic [ADDR_W-1:0] REQ0_ADDR,
  input  logic [DATA_W-1:0] REQ0_DATA,
  output logic              REQ0_READY,
  input  logic              REQ1_VALID,
  input  logic [ADDR_W-1:0] REQ1_ADDR,
  input  logic [DATA_W-1:0] REQ1_DATA,
  output logic              REQ1_READY,
  input  logic [ADDR_W-1:0] RD1_ADDR,
  input  logic [ADDR_W-1:0] RD2_ADDR,
  output logic              RF_WRITE,
  output logic [ADDR_W-1:0] RF_INADDRESS,
  output logic [DATA_W-1:0] RF_IN,
  output logic              HAZARD
);
  logic [1:0] req_valid, v, g, rdy, ld, keep, la, age;
  logic [ADDR_W-1:0] req_addr [2];
  logic [DATA_W-1:0] req_data [2];
  logic [ADDR_W-1:0] sa [2];
  logic [DATA_W-1:0] sd [2];
  logic same, rr_ptr;
  assign req_valid = {REQ1_VALID, REQ0_VALID};
  assign req_addr[REQ_ALU] = REQ0_ADDR;
  assign req_addr[REQ_MEM] = REQ1_ADDR;
  assign req_data[REQ_ALU] = REQ0_DATA;
  assign req_data[REQ_MEM] = REQ1_DATA;
  assign same = sa[0] == sa[1];
  // same destination: age keeps program order; otherwise rr_ptr=1 favours req1
  assign g[0] = v[0] & (!v[1] | (same ? age[0] : (!RR_ENABLE | !rr_ptr)));
  assign g[1] = v[1] & !g[0];
  assign rdy = {2{!RESET}} & (~v | g);
  assign ld = req_valid & rdy;
  assign keep = v & ~g;
  // a new entry is younger than a surviving one; simultaneous capture makes req0 older
  assign la[0] = !keep[1];
  assign la[1] = !keep[0] & !ld[0];
  assign REQ0_READY = rdy[0];
  assign REQ1_READY = rdy[1];
  for (genvar i = 0; i < 2; i++) begin : g_slot
    wb_hold_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot (
      .CLK(CLK),
      .RESET(RESET),
      .load(ld[i]),
      .free(g[i]),
      .load_addr(req_addr[i]),
      .load_data(req_data[i]),
      .load_age(la[i]),
      .valid(v[i]),
      .addr(sa[i]),
      .data(sd[i]),
      .age(age[i])
    );
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RF_WRITE <= 1'b0;
      RF_INADDRESS <= '0;
      RF_IN <= '0;
      rr_ptr <= 1'b0;
    end else begin
      RF_WRITE <= |v;
      if (|v) begin
        RF_INADDRESS <= g[1] ? sa[1] : sa[0];
        RF_IN <= g[1] ? sd[1] : sd[0];
      end
      if (RR_ENABLE && (&v) && !same) rr_ptr <= g[0];
    end
  end
  assign HAZARD = !RESET & (
    (v[0] & (sa[0] == RD1_ADDR | sa[0] == RD2_ADDR)) |
    (v[1] & (sa[1] == RD1_ADDR | sa[1] == RD2_ADDR)) |
    (RF_WRITE & (RF_INADDRESS == RD1_ADDR | RF_INADDRESS == RD2_ADDR)));
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  import regfile_pkg::*;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic [2:0] REQ0_ADDR = '0, REQ1_ADDR = '0, RD1_ADDR = '0, RD2_ADDR = '0;
  logic [7:0] REQ0_DATA = '0, REQ1_DATA = '0;
  logic REQ0_READY, REQ1_READY, RF_WRITE, HAZARD;
  logic [2:0] RF_INADDRESS;
  logic [7:0] RF_IN;
  int checks = 0, errors = 0;
  wb_req_t wlog [$];
  regfile_write_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
    .RD1_ADDR(RD1_ADDR), .RD2_ADDR(RD2_ADDR),
    .RF_WRITE(RF_WRITE), .RF_INADDRESS(RF_INADDRESS), .RF_IN(RF_IN), .HAZARD(HAZARD)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) if (RF_WRITE) wlog.push_back(wb_req_t'{addr: RF_INADDRESS, data: RF_IN});
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic drive(input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                       input logic v1, input logic [2:0] a1, input logic [7:0] d1);
    REQ0_VALID = v0; REQ0_ADDR = a0; REQ0_DATA = d0;
    REQ1_VALID = v1; REQ1_ADDR = a1; REQ1_DATA = d1;
  endtask
  task automatic check_rf(input string tag, input logic we, input logic [2:0] a, input logic [7:0] d);
    check({tag, "_we"}, 32'(RF_WRITE), 32'(we));
    check({tag, "_addr"}, 32'(RF_INADDRESS), 32'(a));
    check({tag, "_data"}, 32'(RF_IN), 32'(d));
  endtask
  initial begin
    int i0, i1;
    logic t0, t1;
    wb_req_t exp4 [4];
    logic [2:0] a0s [2];
    logic [2:0] a1s [2];
    tick;
    tick;
    check_rf("rst", 1'b0, 3'd0, 8'd0);
    check("rst_rdy0", 32'(REQ0_READY), 0);
    check("rst_rdy1", 32'(REQ1_READY), 0);
    check("rst_haz", 32'(HAZARD), 0);
    RESET = 1'b0;
    #1;
    check("idle_rdy0", 32'(REQ0_READY), 1);
    // single write
    drive(1, 3'd5, 8'd54, 0, 3'd0, 8'd0);
    tick;
    drive(0, 3'd0, 8'd0, 0, 3'd0, 8'd0);
    check("t1_pending_we", 32'(RF_WRITE), 0);
    RD1_ADDR = 3'd5;
    #1;
    check("t1_haz_slot", 32'(HAZARD), 1);
    tick;
    check_rf("t1_issue", 1'b1, 3'd5, 8'd54);
    tick;
    check_rf("t1_hold", 1'b0, 3'd5, 8'd54);
    RD1_ADDR = 3'd0;
    // contention, different addresses; second round alternates
    drive(1, 3'd3, 8'd12, 1, 3'd1, 8'd55);
    tick;
    drive(0, 3'd0, 8'd0, 0, 3'd0, 8'd0);
    check("t2_full_rdy0", 32'(REQ0_READY), 1);
    check("t2_full_rdy1", 32'(REQ1_READY), 0);
    tick;
    check_rf("t2_first", 1'b1, 3'd3, 8'd12);
    tick;
    check_rf("t2_second", 1'b1, 3'd1, 8'd55);
    drive(1, 3'd3, 8'd13, 1, 3'd1, 8'd66);
    tick;
    drive(0, 3'd0, 8'd0, 0, 3'd0, 8'd0);
    check("t2b_full_rdy0", 32'(REQ0_READY), 0);
    check("t2b_full_rdy1", 32'(REQ1_READY), 1);
    tick;
    check_rf("t2b_first", 1'b1, 3'd1, 8'd66);
    tick;
    check_rf("t2b_second", 1'b1, 3'd3, 8'd13);
    tick;
    // same address, req1 first
    drive(0, 3'd0, 8'd0, 1, 3'd2, 8'd57);
    tick;
    drive(1, 3'd2, 8'd24, 0, 3'd0, 8'd0);
    tick;
    drive(0, 3'd0, 8'd0, 0, 3'd0, 8'd0);
    check_rf("t3_first", 1'b1, 3'd2, 8'd57);
    tick;
    check_rf("t3_second", 1'b1, 3'd2, 8'd24);
    tick;
    // simultaneous capture, then req0 refills while req1's older entry waits
    drive(1, 3'd2, 8'd24, 1, 3'd2, 8'd57);
    tick;
    drive(1, 3'd2, 8'd30, 0, 3'd0, 8'd0);
    check("t3b_rdy0", 32'(REQ0_READY), 1);
    tick;
    drive(0, 3'd0, 8'd0, 0, 3'd0, 8'd0);
    check_rf("t3b_first", 1'b1, 3'd2, 8'd24);
    tick;
    check_rf("t3b_second", 1'b1, 3'd2, 8'd57);
    tick;
    check_rf("t3b_third", 1'b1, 3'd2, 8'd30);
    tick;
    check("t3b_idle", 32'(RF_WRITE), 0);
    // backpressure: two transfers per requester with VALID held
    wlog.delete();
    a0s[0] = 3'd4; a0s[1] = 3'd5;
    a1s[0] = 3'd6; a1s[1] = 3'd7;
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 8; c++) begin
      drive(i0 < 2, a0s[i0 % 2], 8'(8'h40 + i0), i1 < 2, a1s[i1 % 2], 8'(8'h60 + i1));
      #1;
      t0 = REQ0_VALID & REQ0_READY;
      t1 = REQ1_VALID & REQ1_READY;
      tick;
      i0 += int'(t0);
      i1 += int'(t1);
    end
    drive(0, 3'd0, 8'd0, 0, 3'd0, 8'd0);
    tick;
    exp4[0] = '{addr: 3'd4, data: 8'h40};
    exp4[1] = '{addr: 3'd6, data: 8'h60};
    exp4[2] = '{addr: 3'd5, data: 8'h41};
    exp4[3] = '{addr: 3'd7, data: 8'h61};
    check("t4_count", 32'(wlog.size()), 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("t4_w%0d", k), (k < wlog.size()) ? 32'(wlog[k]) : 32'hffff_ffff, 32'(exp4[k]));
    // hazard through slot and RF_WRITE stage
    drive(1, 3'd6, 8'h77, 0, 3'd0, 8'd0);
    tick;
    drive(0, 3'd0, 8'd0, 0, 3'd0, 8'd0);
    RD2_ADDR = 3'd3;
    #1;
    check("t5_haz_miss", 32'(HAZARD), 0);
    RD2_ADDR = 3'd6;
    #1;
    check("t5_haz_slot", 32'(HAZARD), 1);
    tick;
    check_rf("t5_issue", 1'b1, 3'd6, 8'h77);
    check("t5_haz_rf", 32'(HAZARD), 1);
    tick;
    check("t5_haz_clear", 32'(HAZARD), 0);
    // reset with both slots full and new requests waiting
    drive(1, 3'd1, 8'h11, 1, 3'd2, 8'h22);
    tick;
    drive(1, 3'd3, 8'h33, 1, 3'd4, 8'h44);
    RD1_ADDR = 3'd1;
    RESET = 1'b1;
    #1;
    check("t6_rdy0", 32'(REQ0_READY), 0);
    check("t6_rdy1", 32'(REQ1_READY), 0);
    check("t6_haz", 32'(HAZARD), 0);
    tick;
    check_rf("t6_rst", 1'b0, 3'd0, 8'd0);
    RESET = 1'b0;
    drive(0, 3'd0, 8'd0, 0, 3'd0, 8'd0);
    wlog.delete();
    tick;
    tick;
    tick;
    check("t6_no_stale", 32'(wlog.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
